fwnoc_credit_tx: RTL and testbench
==================================

Name: fwnoc_credit_tx

Overview:
- Link-side transmitter that feeds a remote flit buffer, such as a fwnoc_fifo on the far end of a link, using credit-based flow control in place of a back-propagated ready.
- Accepts 32-bit flits on a ready/valid target port and drives a registered valid/data link with no ready.
- Consumes one credit per flit sent and regains one credit per pulse on the credit-return input.
- Tracks packet boundaries from the header length field so upstream logic and debug can see whether a packet is in progress.

Parameters:
- CREDITS, 2, remote buffer depth; also the credit counter reset value. Must be >= 1.
- CNT_WIDTH, $clog2(CREDITS+1), width of the credit counter and of the credits port.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_dat  in  32  input flit.
- i_valid  in  1  input flit valid.
- i_ready  out  1  input flit accepted when i_valid && i_ready.
- l_dat  out  32  link flit, registered.
- l_valid  out  1  link flit valid, registered, single-cycle per flit; the link has no ready.
- l_credit  in  1  one-cycle pulse; returns one credit.
- credits  out  CNT_WIDTH  current credit count.
- in_pkt  out  1  high while body flits of a packet are outstanding.
- err  out  1  sticky flag for credit overflow.

Behaviour:
- Reset (reset_n low, asynchronous):
  - credits = CREDITS.
  - l_valid = 0; l_dat = 0.
  - FSM = IDLE; remaining = 0; in_pkt = 0; err = 0.
  - Reset asserted mid-packet abandons the packet: no flush, no partial flits.
- Accept: acc = i_valid && i_ready.
  - Base mode: i_ready = (credits != 0), combinational from state only.
  - A credit returning in the same cycle does not raise i_ready that cycle.
- Latency: an accepted flit appears on l_dat with l_valid = 1 exactly one cycle later.
  - l_valid = 0 in any cycle following a non-accept cycle; l_dat holds its last value.
  - Full throughput: one flit per cycle while credits allow.
- Credit counter, decided each cycle on {acc, l_credit}:
  - 10: credits - 1.
  - 01: credits + 1.
  - 11: unchanged.
  - 00: unchanged.
- Overflow: l_credit while credits == CREDITS and !acc leaves credits unchanged and sets err = 1. err stays high until reset.
- Underflow is impossible by construction, since acc requires credits != 0.
- Packet FSM:
  - Header length is len = i_dat[7:0], giving 0..255 body flits.
  - IDLE: an accepted flit is a header.
    - len == 0: stay in IDLE (single-flit packet).
    - Otherwise: remaining <= len, go to BODY.
  - BODY: each accepted flit decrements remaining. The flit accepted with remaining == 1 returns the FSM to IDLE.
- in_pkt = (state == BODY). It rises the cycle after the header is accepted and falls the cycle after the last body flit is accepted.
- Idle input (i_valid = 0) in BODY is legal; the FSM waits with no timeout.
- Data is never inspected beyond i_dat[7:0] of headers and is passed unmodified.

Optional Feature:
- Macro: FWNOC_CREDIT_TX_PKT_ATOMIC_EN.
- Defined:
  - In IDLE, a header is accepted only when credits >= len+1, so the whole packet is reserved up front. i_ready then depends combinationally on i_valid and i_dat[7:0]; i_ready = 0 when i_valid = 0.
  - In BODY, i_ready = 1 unconditionally. This is safe because reserved credits only grow through returns.
  - A header with len+1 > CREDITS is illegal stimulus and is never accepted.
  - Guarantees a packet is never stalled mid-stream on the link.
- Undefined: base rule i_ready = (credits != 0) in all states.

Test Plan:
- Reset check, CREDITS=4: after reset_n rises, credits = 4, i_ready = 1, l_valid = 0, in_pkt = 0, err = 0.
- Packet send, CREDITS=4: header 0x00000002, then bodies 0xA, 0xB, no returns.
  - l_valid = 1 on cycles N+1..N+3 with data 0x2, 0xA, 0xB.
  - in_pkt high after the header, low after 0xB.
  - credits ends at 1.
- Exhaustion, CREDITS=4: four len=0 headers → credits = 0 and i_ready = 0 while i_valid is held high. One l_credit pulse → credits = 1 and i_ready = 1 the next cycle, and the held flit is accepted.
- Simultaneous events: with credits = 1, drive acc and l_credit in the same cycle → credits stays 1, and the flit appears on l_dat next cycle.
- Overflow: at credits = 4, pulse l_credit with no accept → err = 1 and credits = 4. err stays 1 after further traffic and clears only on reset_n.
- Atomic, macro defined, CREDITS=4: with credits = 2, hold header len=2 → i_ready = 0. One l_credit → credits = 3, header accepted, and both body flits are accepted back-to-back with i_ready = 1.

Source files
------------

// File: rtl/fwnoc_credit_tx.sv
// fwnoc_credit_tx: credit-based link transmitter.
//
// Accepts 32-bit flits on a ready/valid port. Each accepted flit is driven one cycle later
// on a registered valid/data link that has no ready. Flow control uses credits instead:
// one credit is spent per flit sent, and one credit comes back per l_credit pulse. The
// header length field (i_dat[7:0]) is tracked so that in_pkt shows when body flits are
// still outstanding.
//
// Optional feature, FWNOC_CREDIT_TX_PKT_ATOMIC_EN: a header is accepted only when enough
// credits are held for the whole packet. Body flits are then always ready.
//
// Ports:
//   clock     in   single clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   i_dat     in   input flit
//   i_valid   in   input flit valid
//   i_ready   out  input flit accepted when i_valid && i_ready
//   l_dat     out  link flit (registered)
//   l_valid   out  link flit valid (registered, one cycle per flit)
//   l_credit  in   one-cycle credit return pulse
//   credits   out  current credit count
//   in_pkt    out  high while body flits of a packet are outstanding
//   err       out  sticky credit-overflow flag
module fwnoc_credit_tx #(
    parameter int unsigned CREDITS   = 2,
    parameter int unsigned CNT_WIDTH = $clog2(CREDITS + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [31:0]          i_dat,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [31:0]          l_dat,
    output logic                 l_valid,
    input  logic                 l_credit,
    output logic [CNT_WIDTH-1:0] credits,
    output logic                 in_pkt,
    output logic                 err
);

    localparam logic [CNT_WIDTH-1:0] MaxCredits = CNT_WIDTH'(CREDITS);
    localparam logic [CNT_WIDTH-1:0] OneCredit  = CNT_WIDTH'(1);

    typedef enum logic {StIdle, StBody} state_e;

    state_e               state_q, state_d;
    logic [7:0]           remaining_q, remaining_d;
    logic [CNT_WIDTH-1:0] credits_q, credits_d;
    logic                 err_q, err_d;
    logic                 l_valid_q;
    logic [31:0]          l_dat_q;
    logic                 acc;
    logic [7:0]           len;

    assign len = i_dat[7:0];

`ifdef FWNOC_CREDIT_TX_PKT_ATOMIC_EN
    // A header must find credits for itself plus all its body flits.
    logic [8:0]  need;
    logic [31:0] have;
    assign need = {1'b0, len} + 9'd1;
    assign have = 32'(credits_q);

    always_comb begin
        i_ready = 1'b0;
        if (state_q == StBody) begin
            // Body credits were reserved by the header and returns only add more.
            i_ready = 1'b1;
        end else begin
            i_ready = i_valid && (have >= 32'(need));
        end
    end
`else
    // This depends only on state, so a credit returned this cycle cannot raise it.
    always_comb begin
        i_ready = (credits_q != '0);
    end
`endif

    assign acc = i_valid && i_ready;

    // Credit counter and overflow detection.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        unique case ({acc, l_credit})
            2'b10: credits_d = credits_q - OneCredit;
            2'b01: begin
                if (credits_q == MaxCredits) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + OneCredit;
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    // Packet boundary tracking.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            StIdle: begin
                if (acc && (len != 8'd0)) begin
                    remaining_d = len;
                    state_d     = StBody;
                end
            end
            StBody: begin
                if (acc) begin
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                remaining_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            remaining_q <= 8'd0;
            credits_q   <= MaxCredits;
            err_q       <= 1'b0;
            l_valid_q   <= 1'b0;
            l_dat_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            credits_q   <= credits_d;
            err_q       <= err_d;
            l_valid_q   <= acc;
            if (acc) begin
                l_dat_q <= i_dat;
            end
        end
    end

    assign l_valid = l_valid_q;
    assign l_dat   = l_dat_q;
    assign credits = credits_q;
    assign in_pkt  = (state_q == StBody);
    assign err     = err_q;

endmodule

// File: tb/tb_fwnoc_credit_tx.sv
// Self-checking bench for fwnoc_credit_tx (CREDITS = 4): directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a reference model.
module tb_fwnoc_credit_tx;

    localparam int unsigned CREDITS = 4;
    localparam int unsigned CW      = $clog2(CREDITS + 1);

    logic          clock = 1'b0;
    logic          reset_n;
    logic [31:0]   i_dat;
    logic          i_valid;
    logic          i_ready;
    logic [31:0]   l_dat;
    logic          l_valid;
    logic          l_credit;
    logic [CW-1:0] credits;
    logic          in_pkt;
    logic          err;

    fwnoc_credit_tx #(
        .CREDITS  (CREDITS),
        .CNT_WIDTH(CW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .i_dat   (i_dat),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .l_dat   (l_dat),
        .l_valid (l_valid),
        .l_credit(l_credit),
        .credits (credits),
        .in_pkt  (in_pkt),
        .err     (err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 0;

    // Reference model: credit count, body flits still owed, and the last flit sent.
    int          m_credits;
    int          m_owed;
    bit          m_err;
    bit          m_lvalid;
    logic [31:0] m_ldat;

    function automatic bit m_ready();
`ifdef FWNOC_CREDIT_TX_PKT_ATOMIC_EN
        if (m_owed > 0) return 1'b1;
        return i_valid && (m_credits >= int'(i_dat[7:0]) + 1);
`else
        return m_credits > 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_credits = CREDITS;
            m_owed    = 0;
            m_err     = 0;
            m_lvalid  = 0;
            m_ldat    = 32'd0;
        end else begin
            bit acc;
            acc = i_valid && m_ready();
            m_lvalid = acc;
            if (acc) begin
                m_ldat = i_dat;
                if (m_owed == 0) m_owed = int'(i_dat[7:0]);
                else m_owed--;
            end
            if (acc && !l_credit) m_credits--;
            else if (!acc && l_credit) begin
                if (m_credits == CREDITS) m_err = 1;
                else m_credits++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (started && reset_n) begin
            chk("m_i_ready", 32'(i_ready), 32'(m_ready()));
            chk("m_credits", 32'(credits), 32'(m_credits));
            chk("m_l_valid", 32'(l_valid), 32'(m_lvalid));
            chk("m_l_dat",   l_dat,        m_ldat);
            chk("m_in_pkt",  32'(in_pkt),  32'(m_owed != 0));
            chk("m_err",     32'(err),     32'(m_err));
        end
    end

    // Apply new inputs just after a rising edge; outputs then reflect that edge.
    task automatic drive(input bit v, input logic [31:0] d, input bit c);
        @(posedge clock);
        #1;
        i_valid  = v;
        i_dat    = d;
        l_credit = c;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        i_valid  = 1'b0;
        i_dat    = 32'd0;
        l_credit = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        do_reset();
        started = 1;

        // Reset state.
        chk("rst_credits", 32'(credits), 32'd4);
`ifndef FWNOC_CREDIT_TX_PKT_ATOMIC_EN
        chk("rst_i_ready", 32'(i_ready), 32'd1);
`endif
        chk("rst_l_valid", 32'(l_valid), 32'd0);
        chk("rst_in_pkt",  32'(in_pkt),  32'd0);
        chk("rst_err",     32'(err),     32'd0);

        // Header len=2, then two bodies.
        drive(1, 32'h2, 0);
        drive(1, 32'hA, 0);
        chk("pkt_v0", 32'(l_valid), 32'd1);
        chk("pkt_d0", l_dat, 32'h2);
        chk("pkt_in0", 32'(in_pkt), 32'd1);
        drive(1, 32'hB, 0);
        chk("pkt_d1", l_dat, 32'hA);
        drive(0, 32'h0, 0);
        chk("pkt_d2", l_dat, 32'hB);
        chk("pkt_v2", 32'(l_valid), 32'd1);
        chk("pkt_in2", 32'(in_pkt), 32'd0);
        chk("pkt_cred", 32'(credits), 32'd1);
        drive(0, 32'h0, 0);
        chk("pkt_idle_v", 32'(l_valid), 32'd0);
        chk("pkt_hold_d", l_dat, 32'hB);

        // Return all three credits.
        repeat (3) drive(0, 32'h0, 1);
        drive(0, 32'h0, 0);
        chk("ret_cred", 32'(credits), 32'd4);

        // Exhaustion with single-flit packets.
        repeat (5) drive(1, 32'h100, 0);
        chk("exh_cred", 32'(credits), 32'd0);
        chk("exh_rdy", 32'(i_ready), 32'd0);
        drive(1, 32'h100, 1);
        chk("exh_rdy_same", 32'(i_ready), 32'd0);
        chk("exh_stall_v", 32'(l_valid), 32'd0);
        drive(1, 32'h100, 0);
        chk("exh_cred1", 32'(credits), 32'd1);
        chk("exh_rdy1", 32'(i_ready), 32'd1);
        drive(0, 32'h0, 0);
        chk("exh_sent_v", 32'(l_valid), 32'd1);
        chk("exh_cred0", 32'(credits), 32'd0);

        // Accept and return in the same cycle at credits = 1.
        drive(0, 32'h0, 1);
        drive(1, 32'h200, 1);
        chk("sim_cred_pre", 32'(credits), 32'd1);
        drive(0, 32'h0, 0);
        chk("sim_cred", 32'(credits), 32'd1);
        chk("sim_d", l_dat, 32'h200);
        chk("sim_v", 32'(l_valid), 32'd1);

`ifdef FWNOC_CREDIT_TX_PKT_ATOMIC_EN
        // Atomic: credits = 2, header len=2 must wait for a third credit.
        drive(0, 32'h0, 1);
        drive(1, 32'h2, 0);
        chk("atm_cred2", 32'(credits), 32'd2);
        chk("atm_rdy0", 32'(i_ready), 32'd0);
        drive(1, 32'h2, 1);
        drive(1, 32'h2, 0);
        chk("atm_cred3", 32'(credits), 32'd3);
        chk("atm_rdy1", 32'(i_ready), 32'd1);
        drive(1, 32'hC, 0);
        chk("atm_body_rdy0", 32'(i_ready), 32'd1);
        drive(1, 32'hD, 0);
        chk("atm_body_rdy1", 32'(i_ready), 32'd1);
        drive(0, 32'h0, 0);
        chk("atm_cred_end", 32'(credits), 32'd0);
        chk("atm_last", l_dat, 32'hD);
        repeat (3) drive(0, 32'h0, 1);
`else
        repeat (2) drive(0, 32'h0, 1);
`endif
        drive(0, 32'h0, 1);
        drive(0, 32'h0, 0);
        chk("ovf_pre_cred", 32'(credits), 32'd4);
        chk("ovf_pre_err", 32'(err), 32'd0);

        // Overflow.
        drive(0, 32'h0, 1);
        drive(0, 32'h0, 0);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_cred", 32'(credits), 32'd4);
        drive(1, 32'h300, 0);
        drive(0, 32'h0, 1);
        drive(0, 32'h0, 0);
        chk("ovf_sticky", 32'(err), 32'd1);

        started = 0;
        do_reset();
        started = 1;
        chk("ovf_clear", 32'(err), 32'd0);

        // Randomized traffic with legal credit returns.
        for (int i = 0; i < 3000; i++) begin
            bit          v;
            bit          c;
            logic [31:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = $urandom;
            if (m_owed == 0) begin
`ifdef FWNOC_CREDIT_TX_PKT_ATOMIC_EN
                d[7:0] = 8'($urandom_range(0, CREDITS - 1));
`else
                d[7:0] = 8'($urandom_range(0, 5));
`endif
            end
            c = (m_credits < CREDITS) && ($urandom_range(0, 2) == 0);
            drive(v, d, c);
        end
        drive(0, 32'h0, 0);
        drive(0, 32'h0, 0);
        chk("rnd_no_err", 32'(err), 32'd0);

        @(negedge clock);
        started = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
